// File: rtl/mem_ctrl_pkg.sv
// Shared phase type, port-A command encodings and UART register addresses
// for the SRAM memory-stage controller (UART addresses used only with UART_MMIO_EN).
package mem_ctrl_pkg;

  typedef enum logic [1:0] {
    P0 = 2'd0,
    P1 = 2'd1,
    P2 = 2'd2,
    P3 = 2'd3
  } phase_t;

  localparam logic [1:0] MEMCTL_NONE    = 2'b00;
  localparam logic [1:0] MEMCTL_READ    = 2'b10;
  localparam logic [1:0] MEMCTL_WRITE   = 2'b01;
  localparam logic [1:0] MEMCTL_ILLEGAL = 2'b11;

  localparam logic [15:0] UART_DATA_ADDR = 16'hBF00;
  localparam logic [15:0] UART_STAT_ADDR = 16'hBF01;

  // The beat is a free-running four-phase ring; there is no stall input.
  function automatic phase_t next_phase(input phase_t p);
    case (p)
      P0:      return P1;
      P1:      return P2;
      P2:      return P3;
      default: return P0;
    endcase
  endfunction

endpackage

// File: rtl/sram_port_seq.sv
// One external-SRAM port: decodes the shared beat phase into CE/OE/WE strobes,
// drives write data and captures read data. WRITE_EN=0 gives a read-only port.
module sram_port_seq
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W   = 16,
  parameter int DATA_W   = 16,
  parameter int SRAM_AW  = 18,
  parameter bit WRITE_EN = 1'b1
) (
  input  logic               clk,
  input  logic               rst,
  input  phase_t             i_phase,
  input  logic               i_rd,
  input  logic               i_wr,
  input  logic               i_sel,
  input  logic [ADDR_W-1:0]  i_addr,
  input  logic [DATA_W-1:0]  i_wdata,
  input  logic [DATA_W-1:0]  i_dq,
  output logic [SRAM_AW-1:0] o_addr,
  output logic [DATA_W-1:0]  o_dq,
  output logic               o_dq_oe,
  output logic               o_ce_n,
  output logic               o_oe_n,
  output logic               o_we_n,
  output logic [DATA_W-1:0]  o_rdata
);

  logic              w_wr;
  logic              r_rd;
  logic              r_wr;
  logic              r_sel;
  logic [DATA_W-1:0] r_wdata;

  assign w_wr = WRITE_EN && i_wr;

  // i_sel=0 keeps the chip deselected while the data bus still runs, so a
  // mapped peripheral sharing the bus can be read or written instead.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_rd    <= 1'b0;
      r_wr    <= 1'b0;
      r_sel   <= 1'b0;
      r_wdata <= '0;
      o_addr  <= '0;
      o_dq    <= '0;
      o_dq_oe <= 1'b0;
      o_ce_n  <= 1'b1;
      o_oe_n  <= 1'b1;
      o_we_n  <= 1'b1;
      o_rdata <= '0;
    end else begin
      case (i_phase)
        P0: begin
          r_rd    <= i_rd;
          r_wr    <= w_wr;
          r_sel   <= i_sel;
          r_wdata <= i_wdata;
          o_addr  <= {{(SRAM_AW-ADDR_W){1'b0}}, i_addr};
          o_ce_n  <= !(i_sel && (i_rd || w_wr));
        end
        P1: begin
          if (r_wr) begin
            o_dq_oe <= 1'b1;
            o_dq    <= r_wdata;
          end
          o_we_n <= !(r_wr && r_sel);
          o_oe_n <= !(r_rd && r_sel);
        end
        P2: begin
          o_we_n <= 1'b1;
          if (r_rd) o_rdata <= i_dq;
        end
        default: begin
          o_dq_oe <= 1'b0;
          o_ce_n  <= 1'b1;
          o_oe_n  <= 1'b1;
          o_we_n  <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/sram_mem_controller.sv
// Memory-stage back-end: port A (data, RAM1) and port B (fetch, RAM2) on a 4-phase beat.
// Define UART_MMIO_EN to map the UART at 0xBF00/0xBF01 onto the RAM1 data bus.
module sram_mem_controller
  import mem_ctrl_pkg::*;
#(
  parameter int ADDR_W  = 16,
  parameter int DATA_W  = 16,
  parameter int SRAM_AW = 18
) (
  input  logic               clk,
  input  logic               rst,
`ifdef UART_MMIO_EN
  output logic               uart_rdn,
  output logic               uart_wrn,
  input  logic               uart_data_ready,
  input  logic               uart_tbre,
  input  logic               uart_tsre,
`endif
  output logic               cpu_ce,
  input  logic [ADDR_W-1:0]  a_addr,
  input  logic [1:0]         a_ctrl,
  input  logic [DATA_W-1:0]  a_wdata,
  output logic [DATA_W-1:0]  a_rdata,
  input  logic [ADDR_W-1:0]  b_addr,
  output logic [DATA_W-1:0]  b_rdata,
  output logic               ctrl_err,
  output logic [SRAM_AW-1:0] ram1_addr,
  output logic [DATA_W-1:0]  ram1_dq_o,
  output logic               ram1_dq_oe,
  input  logic [DATA_W-1:0]  ram1_dq_i,
  output logic               ram1_ce_n,
  output logic               ram1_oe_n,
  output logic               ram1_we_n,
  output logic [SRAM_AW-1:0] ram2_addr,
  input  logic [DATA_W-1:0]  ram2_dq_i,
  output logic               ram2_ce_n,
  output logic               ram2_oe_n,
  output logic               ram2_we_n
);

  phase_t            r_phase;
  logic              w_aRd;
  logic              w_aWr;
  logic              w_aIll;
  logic              w_ram1Sel;
  logic              w_ram1Wr;
  logic [DATA_W-1:0] w_ram1Dq;
  logic [DATA_W-1:0] w_unusedRam2Dq;
  logic              w_unusedRam2DqOe;

  always_comb begin
    w_aRd  = 1'b0;
    w_aWr  = 1'b0;
    w_aIll = 1'b0;
    case (a_ctrl)
      MEMCTL_READ:    w_aRd  = 1'b1;
      MEMCTL_WRITE:   w_aWr  = 1'b1;
      MEMCTL_ILLEGAL: w_aIll = 1'b1;
      MEMCTL_NONE:    ;
      default:        ;
    endcase
  end

  // The illegal command is flagged once per latched beat and only cleared by reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_phase  <= P0;
      cpu_ce   <= 1'b0;
      ctrl_err <= 1'b0;
    end else begin
      r_phase <= next_phase(r_phase);
      cpu_ce  <= (r_phase == P3);
      if (r_phase == P0 && w_aIll) ctrl_err <= 1'b1;
    end
  end

`ifdef UART_MMIO_EN
  logic w_uartData;
  logic w_uartStat;
  logic r_uartRd;
  logic r_uartWr;
  logic r_uartStat;

  assign w_uartData = (a_addr == ADDR_W'(UART_DATA_ADDR));
  assign w_uartStat = (a_addr == ADDR_W'(UART_STAT_ADDR));
  assign w_ram1Sel  = !(w_uartData || w_uartStat);
  assign w_ram1Wr   = w_aWr && !w_uartStat;
  assign w_ram1Dq   = r_uartStat ?
                      {{(DATA_W-2){1'b0}}, uart_data_ready, uart_tbre & uart_tsre} :
                      ram1_dq_i;

  // UART strobes ride the same phases as the SRAM OE/WE they replace.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_uartRd   <= 1'b0;
      r_uartWr   <= 1'b0;
      r_uartStat <= 1'b0;
      uart_rdn   <= 1'b1;
      uart_wrn   <= 1'b1;
    end else begin
      case (r_phase)
        P0: begin
          r_uartRd   <= w_aRd && w_uartData;
          r_uartWr   <= w_aWr && w_uartData;
          r_uartStat <= w_aRd && w_uartStat;
        end
        P1: begin
          if (r_uartRd) uart_rdn <= 1'b0;
          if (r_uartWr) uart_wrn <= 1'b0;
        end
        P2:      uart_wrn <= 1'b1;
        default: uart_rdn <= 1'b1;
      endcase
    end
  end
`else
  assign w_ram1Sel = 1'b1;
  assign w_ram1Wr  = w_aWr;
  assign w_ram1Dq  = ram1_dq_i;
`endif

  sram_port_seq #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .SRAM_AW (SRAM_AW),
    .WRITE_EN(1'b1)
  ) u_ram1 (
    .clk    (clk),
    .rst    (rst),
    .i_phase(r_phase),
    .i_rd   (w_aRd),
    .i_wr   (w_ram1Wr),
    .i_sel  (w_ram1Sel),
    .i_addr (a_addr),
    .i_wdata(a_wdata),
    .i_dq   (w_ram1Dq),
    .o_addr (ram1_addr),
    .o_dq   (ram1_dq_o),
    .o_dq_oe(ram1_dq_oe),
    .o_ce_n (ram1_ce_n),
    .o_oe_n (ram1_oe_n),
    .o_we_n (ram1_we_n),
    .o_rdata(a_rdata)
  );

  // Instruction fetch reads every beat; its write path is built out.
  sram_port_seq #(
    .ADDR_W  (ADDR_W),
    .DATA_W  (DATA_W),
    .SRAM_AW (SRAM_AW),
    .WRITE_EN(1'b0)
  ) u_ram2 (
    .clk    (clk),
    .rst    (rst),
    .i_phase(r_phase),
    .i_rd   (1'b1),
    .i_wr   (1'b0),
    .i_sel  (1'b1),
    .i_addr (b_addr),
    .i_wdata('0),
    .i_dq   (ram2_dq_i),
    .o_addr (ram2_addr),
    .o_dq   (w_unusedRam2Dq),
    .o_dq_oe(w_unusedRam2DqOe),
    .o_ce_n (ram2_ce_n),
    .o_oe_n (ram2_oe_n),
    .o_we_n (ram2_we_n),
    .o_rdata(b_rdata)
  );

endmodule

// File: tb/tb_sram_mem_controller.sv
// Testbench for sram_mem_controller: SRAM models on both ports plus a beat-level
// reference model; UART tests run only when UART_MMIO_EN is defined.
module tb_sram_mem_controller;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        cpu_ce;
  logic [15:0] a_addr, a_wdata, a_rdata, b_addr, b_rdata;
  logic [1:0]  a_ctrl;
  logic        ctrl_err;
  logic [17:0] ram1_addr, ram2_addr;
  logic [15:0] ram1_dq_o, ram1_dq_i, ram2_dq_i;
  logic        ram1_dq_oe, ram1_ce_n, ram1_oe_n, ram1_we_n;
  logic        ram2_ce_n, ram2_oe_n, ram2_we_n;
`ifdef UART_MMIO_EN
  logic        uart_rdn, uart_wrn;
  logic        uart_data_ready = 1'b0, uart_tbre = 1'b0, uart_tsre = 1'b0;
  localparam logic [15:0] UART_RX = 16'h0055;
`endif

  int nCmp = 0;
  int nFail = 0;

  // Physical RAM contents (written only by the RAM1 model) and the reference copy.
  logic [15:0] mem1 [int];
  logic [15:0] refMem1 [int];
  logic [15:0] mem2 [0:65535];
  logic [15:0] expA;
  logic        expErr;

  logic [3:0]  obsCe, obsOe, obsWe, obsDqOe, obsCpuCe, obsRdn, obsWrn;
  logic        obsClash;
  logic [17:0] obsAddr1, obsAddr2;
  logic [15:0] obsDqO;

  always #5 clk = ~clk;

  sram_mem_controller dut (
    .clk(clk), .rst(rst),
`ifdef UART_MMIO_EN
    .uart_rdn(uart_rdn), .uart_wrn(uart_wrn), .uart_data_ready(uart_data_ready),
    .uart_tbre(uart_tbre), .uart_tsre(uart_tsre),
`endif
    .cpu_ce(cpu_ce), .a_addr(a_addr), .a_ctrl(a_ctrl), .a_wdata(a_wdata), .a_rdata(a_rdata),
    .b_addr(b_addr), .b_rdata(b_rdata), .ctrl_err(ctrl_err),
    .ram1_addr(ram1_addr), .ram1_dq_o(ram1_dq_o), .ram1_dq_oe(ram1_dq_oe), .ram1_dq_i(ram1_dq_i),
    .ram1_ce_n(ram1_ce_n), .ram1_oe_n(ram1_oe_n), .ram1_we_n(ram1_we_n),
    .ram2_addr(ram2_addr), .ram2_dq_i(ram2_dq_i), .ram2_ce_n(ram2_ce_n),
    .ram2_oe_n(ram2_oe_n), .ram2_we_n(ram2_we_n)
  );

  // Power-up contents of RAM1 are a fixed scramble of the address.
  function automatic logic [15:0] init1(input int a);
    return 16'(a * 40503) ^ 16'h5A5A;
  endfunction

  function automatic logic [15:0] phys1(input int a);
    return mem1.exists(a) ? mem1[a] : init1(a);
  endfunction

  function automatic logic [15:0] ref1(input int a);
    return refMem1.exists(a) ? refMem1[a] : init1(a);
  endfunction

  // Asynchronous SRAM models: read data only while CE and OE are both low.
  always_comb begin
    ram1_dq_i = 16'hDEAD;
    if (!ram1_ce_n && !ram1_oe_n) ram1_dq_i = phys1(int'(ram1_addr));
`ifdef UART_MMIO_EN
    if (!uart_rdn) ram1_dq_i = UART_RX;
`endif
  end

  always_comb begin
    ram2_dq_i = 16'hDEAD;
    if (!ram2_ce_n && !ram2_oe_n && ram2_addr[17:16] == 2'b00) ram2_dq_i = mem2[ram2_addr[15:0]];
  end

  always @(posedge clk) begin
    if (!ram1_ce_n && !ram1_we_n && ram1_dq_oe) mem1[int'(ram1_addr)] = ram1_dq_o;
  end

  // Reference model: what one beat should do to the load register, error flag and memory.
  task automatic model_beat(input logic [1:0] ctrl, input logic [15:0] addr, input logic [15:0] wdata);
    if (ctrl == 2'b11) expErr = 1'b1;
`ifdef UART_MMIO_EN
    if (addr == 16'hBF01) begin
      if (ctrl == 2'b10) expA = {14'b0, uart_data_ready, uart_tbre & uart_tsre};
      return;
    end
    if (addr == 16'hBF00) begin
      if (ctrl == 2'b10) expA = UART_RX;
      return;
    end
`endif
    if (ctrl == 2'b10) expA = ref1(int'(addr));
    else if (ctrl == 2'b01) refMem1[int'(addr)] = wdata;
  endtask

  // Drive one request just before its latching edge and record the 4 cycles that follow.
  task automatic applyStimulus(input logic [1:0] ctrl, input logic [15:0] addr,
                               input logic [15:0] wdata, input logic [15:0] baddr);
    a_ctrl = ctrl; a_addr = addr; a_wdata = wdata; b_addr = baddr;
    model_beat(ctrl, addr, wdata);
    obsCe = '0; obsOe = '0; obsWe = '0; obsDqOe = '0; obsCpuCe = '0; obsRdn = '0; obsWrn = '0;
    obsClash = 1'b0;
    for (int k = 0; k < 4; k++) begin
      @(posedge clk); #1;
      obsCe[k] = !ram1_ce_n; obsOe[k] = !ram1_oe_n; obsWe[k] = !ram1_we_n;
      obsDqOe[k] = ram1_dq_oe; obsCpuCe[k] = cpu_ce;
      if (!ram1_oe_n && ram1_dq_oe) obsClash = 1'b1;
`ifdef UART_MMIO_EN
      obsRdn[k] = !uart_rdn; obsWrn[k] = !uart_wrn;
`endif
      if (k == 1) begin obsAddr1 = ram1_addr; obsAddr2 = ram2_addr; obsDqO = ram1_dq_o; end
    end
  endtask

  task automatic test_reset;
    rst = 1'b0; a_ctrl = 2'b00; a_addr = '0; a_wdata = '0; b_addr = '0;
    expA = '0; expErr = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    nCmp++; if (cpu_ce !== 1'b0) begin nFail++; $display("[TB] FAIL rst_cpu_ce got %b want 0", cpu_ce); end
    nCmp++; if ({a_rdata, b_rdata} !== 32'h0) begin nFail++; $display("[TB] FAIL rst_rdata got %h want 0", {a_rdata, b_rdata}); end
    nCmp++; if ({ram1_ce_n, ram1_oe_n, ram1_we_n, ram2_ce_n, ram2_oe_n, ram2_we_n, ram1_dq_oe} !== 7'b1111110) begin
      nFail++; $display("[TB] FAIL rst_strobes got %b want 1111110", {ram1_ce_n, ram1_oe_n, ram1_we_n, ram2_ce_n, ram2_oe_n, ram2_we_n, ram1_dq_oe}); end
    nCmp++; if ({ram1_addr, ram2_addr, ctrl_err} !== 37'h0) begin nFail++; $display("[TB] FAIL rst_addr_err got %h want 0", {ram1_addr, ram2_addr, ctrl_err}); end
    @(negedge clk); rst = 1'b1;
    applyStimulus(2'b00, 16'h0000, 16'h0000, 16'h0004);
    nCmp++; if (obsCpuCe !== 4'b1000) begin nFail++; $display("[TB] FAIL rst_first_ce got %b want 1000", obsCpuCe); end
    nCmp++; if (obsCe !== 4'b0000) begin nFail++; $display("[TB] FAIL idle_ram1_ce got %b want 0000", obsCe); end
    nCmp++; if (a_rdata !== 16'h0000) begin nFail++; $display("[TB] FAIL idle_a_rdata got %h want 0000", a_rdata); end
  endtask

  task automatic test_write_read;
    applyStimulus(2'b01, 16'h0010, 16'hBEEF, 16'h0000);
    nCmp++; if (obsWe !== 4'b0010) begin nFail++; $display("[TB] FAIL wr_we_n got %b want 0010", obsWe); end
    nCmp++; if (obsDqOe !== 4'b0110) begin nFail++; $display("[TB] FAIL wr_dq_oe got %b want 0110", obsDqOe); end
    nCmp++; if (obsCe !== 4'b0111 || obsOe !== 4'b0000) begin nFail++; $display("[TB] FAIL wr_ce_oe got %b/%b want 0111/0000", obsCe, obsOe); end
    nCmp++; if (obsDqO !== 16'hBEEF || obsAddr1 !== 18'h00010) begin nFail++; $display("[TB] FAIL wr_bus got %h@%h want beef@00010", obsDqO, obsAddr1); end
    applyStimulus(2'b10, 16'h0010, 16'h0000, 16'h0001);
    nCmp++; if (a_rdata !== 16'hBEEF) begin nFail++; $display("[TB] FAIL rd_back got %h want beef", a_rdata); end
    nCmp++; if (obsOe !== 4'b0110 || obsDqOe !== 4'b0000) begin nFail++; $display("[TB] FAIL rd_oe_dq got %b/%b want 0110/0000", obsOe, obsDqOe); end
  endtask

  task automatic test_fetch;
    applyStimulus(2'b01, 16'h0020, 16'hCAFE, 16'h0004);
    nCmp++; if (b_rdata !== 16'h1234) begin nFail++; $display("[TB] FAIL fetch_b got %h want 1234", b_rdata); end
    nCmp++; if (obsAddr2 !== 18'h00004) begin nFail++; $display("[TB] FAIL fetch_addr got %h want 00004", obsAddr2); end
    nCmp++; if (obsWe !== 4'b0010) begin nFail++; $display("[TB] FAIL fetch_wr_we got %b want 0010", obsWe); end
    applyStimulus(2'b10, 16'h0020, 16'h0000, 16'h0005);
    nCmp++; if (a_rdata !== 16'hCAFE) begin nFail++; $display("[TB] FAIL fetch_wr_back got %h want cafe", a_rdata); end
    nCmp++; if (b_rdata !== mem2[5]) begin nFail++; $display("[TB] FAIL fetch_b5 got %h want %h", b_rdata, mem2[5]); end
  endtask

  task automatic test_wrap;
    applyStimulus(2'b01, 16'hFFFF, 16'h5A5A, 16'hFFFF);
    nCmp++; if (obsAddr1 !== 18'h0FFFF) begin nFail++; $display("[TB] FAIL wrap_addr got %h want 0ffff", obsAddr1); end
    applyStimulus(2'b10, 16'hFFFF, 16'h0000, 16'h0000);
    nCmp++; if (a_rdata !== 16'h5A5A) begin nFail++; $display("[TB] FAIL wrap_rd got %h want 5a5a", a_rdata); end
  endtask

  task automatic test_random;
    logic [1:0]  ctrl;
    logic [15:0] addr, wdata, baddr;
    logic [3:0]  expCe, expOe, expWe, expDqOe;
    for (int i = 0; i < 60; i++) begin
      ctrl = 2'($urandom);
      addr = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 15));
      if (addr[15:1] == 15'h5F80) addr = addr ^ 16'h0100;
      wdata = 16'($urandom);
      baddr = 16'($urandom);
      expCe   = (ctrl == 2'b10 || ctrl == 2'b01) ? 4'b0111 : 4'b0000;
      expOe   = (ctrl == 2'b10) ? 4'b0110 : 4'b0000;
      expWe   = (ctrl == 2'b01) ? 4'b0010 : 4'b0000;
      expDqOe = (ctrl == 2'b01) ? 4'b0110 : 4'b0000;
      applyStimulus(ctrl, addr, wdata, baddr);
      nCmp++; if (a_rdata !== expA) begin nFail++; $display("[TB] FAIL rnd_a beat %0d got %h want %h", i, a_rdata, expA); end
      nCmp++; if (b_rdata !== mem2[baddr]) begin nFail++; $display("[TB] FAIL rnd_b beat %0d got %h want %h", i, b_rdata, mem2[baddr]); end
      nCmp++; if (ctrl_err !== expErr) begin nFail++; $display("[TB] FAIL rnd_err beat %0d got %b want %b", i, ctrl_err, expErr); end
      nCmp++; if ({obsCe, obsOe, obsWe, obsDqOe} !== {expCe, expOe, expWe, expDqOe}) begin
        nFail++; $display("[TB] FAIL rnd_strobes beat %0d got %h want %h", i, {obsCe, obsOe, obsWe, obsDqOe}, {expCe, expOe, expWe, expDqOe}); end
      nCmp++; if (obsCpuCe !== 4'b1000 || obsClash !== 1'b0) begin nFail++; $display("[TB] FAIL rnd_ce_clash beat %0d got %b/%b want 1000/0", i, obsCpuCe, obsClash); end
      if (expCe != 4'b0000) begin
        nCmp++; if (obsAddr1 !== {2'b00, addr}) begin nFail++; $display("[TB] FAIL rnd_addr beat %0d got %h want %h", i, obsAddr1, {2'b00, addr}); end
      end
    end
  endtask

  task automatic test_illegal;
    logic [15:0] prevA;
    prevA = expA;
    applyStimulus(2'b11, 16'h0030, 16'h1111, 16'h0000);
    nCmp++; if ({obsCe, obsOe, obsWe, obsDqOe} !== 16'h0) begin nFail++; $display("[TB] FAIL ill_strobes got %h want 0000", {obsCe, obsOe, obsWe, obsDqOe}); end
    nCmp++; if (ctrl_err !== 1'b1) begin nFail++; $display("[TB] FAIL ill_err got %b want 1", ctrl_err); end
    nCmp++; if (a_rdata !== prevA) begin nFail++; $display("[TB] FAIL ill_hold got %h want %h", a_rdata, prevA); end
    applyStimulus(2'b00, 16'h0000, 16'h0000, 16'h0000);
    applyStimulus(2'b10, 16'h0010, 16'h0000, 16'h0000);
    nCmp++; if (ctrl_err !== 1'b1) begin nFail++; $display("[TB] FAIL ill_sticky got %b want 1", ctrl_err); end
    nCmp++; if (a_rdata !== 16'hBEEF) begin nFail++; $display("[TB] FAIL ill_after_rd got %h want beef", a_rdata); end
  endtask

  task automatic test_reset_mid_write;
    logic [15:0] oldVal;
    oldVal = ref1(32'h40);
    a_ctrl = 2'b01; a_addr = 16'h0040; a_wdata = ~oldVal; b_addr = 16'h0000;
    repeat (2) @(posedge clk);
    #1;
    nCmp++; if (ram1_we_n !== 1'b0 || ram1_dq_oe !== 1'b1) begin nFail++; $display("[TB] FAIL mid_p1 got we_n=%b oe=%b want 0/1", ram1_we_n, ram1_dq_oe); end
    #2 rst = 1'b0;
    #1;
    nCmp++; if ({ram1_we_n, ram1_dq_oe, ram1_ce_n} !== 3'b101) begin nFail++; $display("[TB] FAIL mid_async got %b want 101", {ram1_we_n, ram1_dq_oe, ram1_ce_n}); end
    expA = '0; expErr = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    nCmp++; if (phys1(32'h40) !== oldVal) begin nFail++; $display("[TB] FAIL mid_nowrite got %h want %h", phys1(32'h40), oldVal); end
    nCmp++; if (ctrl_err !== 1'b0 || a_rdata !== 16'h0) begin nFail++; $display("[TB] FAIL mid_clear got %b/%h want 0/0000", ctrl_err, a_rdata); end
    @(negedge clk); rst = 1'b1;
    applyStimulus(2'b10, 16'h0040, 16'h0000, 16'h0000);
    nCmp++; if (a_rdata !== oldVal || obsCpuCe !== 4'b1000) begin nFail++; $display("[TB] FAIL mid_restart got %h/%b want %h/1000", a_rdata, obsCpuCe, oldVal); end
  endtask

`ifdef UART_MMIO_EN
  task automatic test_uart;
    uart_data_ready = 1'b1; uart_tbre = 1'b1; uart_tsre = 1'b1;
    applyStimulus(2'b10, 16'hBF01, 16'h0000, 16'h0000);
    nCmp++; if (a_rdata !== 16'h0003) begin nFail++; $display("[TB] FAIL uart_stat got %h want 0003", a_rdata); end
    nCmp++; if (obsCe !== 4'b0000) begin nFail++; $display("[TB] FAIL uart_stat_ce got %b want 0000", obsCe); end
    applyStimulus(2'b01, 16'hBF00, 16'h0041, 16'h0000);
    nCmp++; if (obsWrn !== 4'b0010) begin nFail++; $display("[TB] FAIL uart_wrn got %b want 0010", obsWrn); end
    nCmp++; if (obsCe !== 4'b0000 || obsWe !== 4'b0000 || obsDqO !== 16'h0041) begin nFail++; $display("[TB] FAIL uart_wr_bus got %b/%b/%h want 0000/0000/0041", obsCe, obsWe, obsDqO); end
    applyStimulus(2'b10, 16'hBF00, 16'h0000, 16'h0000);
    nCmp++; if (a_rdata !== UART_RX || obsRdn !== 4'b0110) begin nFail++; $display("[TB] FAIL uart_rd got %h/%b want %h/0110", a_rdata, obsRdn, UART_RX); end
  endtask
`endif

  initial begin
    for (int i = 0; i < 65536; i++) mem2[i] = 16'($urandom);
    mem2[4] = 16'h1234;
    test_reset();
    test_write_read();
    test_fetch();
    test_wrap();
    test_random();
    test_illegal();
    test_reset_mid_write();
`ifdef UART_MMIO_EN
    test_uart();
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", nCmp, nFail);
    $finish;
  end

endmodule
